// File: rtl/scanout_pkg.sv
// scanout_pkg: screen geometry, widths and shared types for the screen scanout block
package scanout_pkg;
  localparam int SCR_WORDS_PER_ROW = 32;
  localparam int SCR_ROWS = 256;
  localparam int SCR_ADR_W = 13;
  localparam int WORD_W = 16;
  localparam int CNT_W = 12;
  typedef logic [SCR_ADR_W-1:0] scr_adr_t;
  typedef logic [WORD_W-1:0] word_t;
  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [$clog2(SCR_ROWS)-1:0] row_t;
  typedef logic [$clog2(SCR_WORDS_PER_ROW)-1:0] col_t;
endpackage

// File: rtl/scanout_timing.sv
// scanout_timing: pixel divider, raster counters, sync/active decode and fetch request.
// SCANOUT_LINE_DOUBLE_EN maps two display lines onto each screen row.
module scanout_timing import scanout_pkg::*; #(
  parameter int PIX_DIV = 2,
  parameter int H_ACTIVE = 512,
  parameter int H_FP = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP = 176,
  parameter int V_ACTIVE = 256,
  parameter int V_FP = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP = 257
) (
  input  logic clk,
  input  logic reset,
  output logic tick,
  output logic active,
  output logic load,
  output logic origin,
  output logic hsync_raw,
  output logic vsync_raw,
  output logic fetch,
  output col_t fetch_word,
  output row_t fetch_row
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam cnt_t DIV_MAX = cnt_t'(PIX_DIV - 1);
  localparam cnt_t HT1 = cnt_t'(H_TOTAL - 1);
  localparam cnt_t HT2 = cnt_t'(H_TOTAL - 2);
  localparam cnt_t VT1 = cnt_t'(V_TOTAL - 1);
  localparam cnt_t HA = cnt_t'(H_ACTIVE);
  localparam cnt_t VA = cnt_t'(V_ACTIVE);
  localparam cnt_t HS0 = cnt_t'(H_ACTIVE + H_FP);
  localparam cnt_t HS1 = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam cnt_t VS0 = cnt_t'(V_ACTIVE + V_FP);
  localparam cnt_t VS1 = cnt_t'(V_ACTIVE + V_FP + V_SYNC);
  cnt_t div, hc, vc, vn, hc2;
  logic wrap_fetch;
  always_ff @(posedge clk)
    if (reset) begin
      div <= '0;
      hc <= HT2;
      vc <= VT1;
    end else begin
      div <= tick ? '0 : div + 1'b1;
      if (tick) begin
        hc <= (hc == HT1) ? '0 : hc + 1'b1;
        if (hc == HT1) vc <= vn;
      end
    end
  // Fetches run two pixels ahead; word 0 of a line is fetched at the end of the previous line.
  always_comb begin
    tick = div == DIV_MAX;
    vn = (vc == VT1) ? '0 : vc + 1'b1;
    hc2 = hc + cnt_t'(2);
    wrap_fetch = hc == HT2;
    active = hc < HA && vc < VA;
    load = active && hc[3:0] == 4'd0;
    origin = hc == '0 && vc == '0;
    hsync_raw = hc >= HS0 && hc < HS1;
    vsync_raw = vc >= VS0 && vc < VS1;
    fetch = tick && (wrap_fetch ? vn < VA : (hc2[3:0] == 4'd0 && hc2 < HA && vc < VA));
    fetch_word = wrap_fetch ? '0 : hc2[8:4];
`ifdef SCANOUT_LINE_DOUBLE_EN
    fetch_row = wrap_fetch ? vn[8:1] : vc[8:1];
`else
    fetch_row = wrap_fetch ? vn[7:0] : vc[7:0];
`endif
  end
endmodule

// File: rtl/screen_scanout.sv
// screen_scanout: reads the screen RAM and serialises it into a pixel stream with syncs and de.
// SCANOUT_LINE_DOUBLE_EN (in scanout_timing) shows each screen row on two lines.
module screen_scanout import scanout_pkg::*; #(
  parameter int PIX_DIV = 2,
  parameter int H_ACTIVE = 512,
  parameter int H_FP = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP = 176,
  parameter int V_ACTIVE = 256,
  parameter int V_FP = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP = 257,
  parameter logic SYNC_ACT = 1'b0
) (
  input  logic clk,
  input  logic reset,
  output logic scr_rd_en,
  output logic [SCR_ADR_W-1:0] scr_adr,
  input  logic [WORD_W-1:0] scr_data,
  output logic pix,
  output logic de,
  output logic hsync,
  output logic vsync,
  output logic frame_start
);
  logic tick, active, load, origin, hsync_raw, vsync_raw, fetch, rd_q;
  col_t fetch_word;
  row_t fetch_row;
  word_t next_word, shift_reg, ld_word, sh_nxt;
  scanout_timing #(
    .PIX_DIV(PIX_DIV), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk(clk), .reset(reset), .tick(tick), .active(active), .load(load), .origin(origin),
    .hsync_raw(hsync_raw), .vsync_raw(vsync_raw), .fetch(fetch),
    .fetch_word(fetch_word), .fetch_row(fetch_row)
  );
  // At one clk per pixel the returned word arrives on the load tick itself, so bypass it.
  always_comb begin
    ld_word = rd_q ? scr_data : next_word;
    sh_nxt = load ? ld_word : shift_reg >> 1;
  end
  always_ff @(posedge clk)
    if (reset) begin
      scr_rd_en <= 1'b0;
      scr_adr <= '0;
      rd_q <= 1'b0;
      next_word <= '0;
      shift_reg <= '0;
      pix <= 1'b0;
      de <= 1'b0;
      hsync <= ~SYNC_ACT;
      vsync <= ~SYNC_ACT;
      frame_start <= 1'b0;
    end else begin
      scr_rd_en <= fetch;
      if (fetch) scr_adr <= {fetch_row, fetch_word};
      rd_q <= scr_rd_en;
      if (rd_q) next_word <= scr_data;
      frame_start <= tick && origin;
      if (tick) begin
        shift_reg <= sh_nxt;
        pix <= active && sh_nxt[0];
        de <= active;
        hsync <= hsync_raw ? SYNC_ACT : ~SYNC_ACT;
        vsync <= vsync_raw ? SYNC_ACT : ~SYNC_ACT;
      end
    end
endmodule
